// File: rtl/memaddr_pkg.sv
// Shared types and helpers for the pipelined memory address-calculation unit.
package memaddr_pkg;

    localparam int UOP_BR_W = 16;

    localparam logic [6:0] UOPC_LD  = 7'h01;
    localparam logic [6:0] UOPC_STA = 7'h02;
    localparam logic [6:0] UOPC_AMO = 7'h43;
    localparam logic [4:0] M_SFENCE = 5'h14;

    typedef enum logic [3:0] {
        CAUSE_NONE        = 4'd0,
        CAUSE_LD_MISALIGN = 4'd4,
        CAUSE_LD_FAULT    = 4'd5,
        CAUSE_ST_MISALIGN = 4'd6,
        CAUSE_ST_FAULT    = 4'd7
    } mxcpt_cause_e;

    typedef struct packed {
        logic [6:0]          uopc;
        logic                is_std;
        logic [UOP_BR_W-1:0] br_mask;
        logic [19:0]         imm_packed;
        logic [4:0]          mem_cmd;
        logic [1:0]          mem_size;
        logic                fp_val;
    } uop_t;

    // Squeeze bits [xlen-1:vbits-1] into one sign-like bit, then sign-extend the
    // vbits-wide result by one bit so canonical addresses keep their true top bit.
    function automatic logic [64:0] canon_compress(input logic [63:0] a,
                                                   input int xlen,
                                                   input int vbits);
        logic       all_ones;
        logic       any_one;
        logic       sign;
        logic       msb;
        logic [64:0] res;
        all_ones = 1'b1;
        any_one  = 1'b0;
        sign     = 1'b0;
        res      = '0;
        for (int i = 0; i < 64; i++) begin
            if (i >= vbits - 1 && i < xlen) begin
                all_ones = all_ones & a[i];
                any_one  = any_one | a[i];
            end
            if (i == vbits - 1) sign = a[i];
        end
        msb = sign ? all_ones : any_one;
        for (int i = 0; i < 65; i++) begin
            if (i < vbits - 1) res[i] = a[i];
            else if (i == vbits - 1 || i == vbits) res[i] = msb;
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_addr_calc_stage.sv
// One pipe register of the address-calc pipe: valid, branch-mask tracking, kill and stall.
module mem_addr_calc_stage #(
    parameter int DATA_W = 8,
    parameter int BR_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [BR_W-1:0]   in_br_mask,
    input  logic [DATA_W-1:0] in_data,
    input  logic [BR_W-1:0]   resolve,
    input  logic [BR_W-1:0]   mispredict,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [BR_W-1:0]   out_br_mask,
    output logic [DATA_W-1:0] out_data
);

    logic              vld_q;
    logic [BR_W-1:0]   mask_q;
    logic [DATA_W-1:0] data_q;
    logic              load;
    logic              kill_in;
    logic              kill_held;

    assign load      = !vld_q || out_ready;
    assign kill_in   = (in_br_mask & mispredict) != '0;
    assign kill_held = (mask_q & mispredict) != '0;

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            vld_q <= 1'b0;
        end else if (load) begin
            vld_q <= in_valid && !kill_in;
        end else if (kill_held) begin
            vld_q <= 1'b0;
        end
    end

    // Data is never reset; stale contents are masked by vld_q.
    always_ff @(posedge clock) begin
        if (load) begin
            data_q <= in_data;
            mask_q <= in_br_mask & ~resolve;
        end else begin
            mask_q <= mask_q & ~resolve;
        end
    end

    assign out_valid   = vld_q;
    assign out_br_mask = mask_q;
    assign out_data    = data_q;

endmodule

// File: rtl/mem_addr_calc_pipe.sv
// Pipelined load/store address calculation with alignment/canonical checks and branch pruning.
module mem_addr_calc_pipe
    import memaddr_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int VADDR_BITS = 39,
    parameter int BR_W       = 16,
    parameter int LATENCY    = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_req_valid,
    output logic                  io_req_ready,
    input  uop_t                  io_req_bits_uop,
    input  logic [XLEN:0]         io_req_bits_rs1_data,
    input  logic [XLEN:0]         io_req_bits_rs2_data,
    input  logic [BR_W-1:0]       io_brupdate_resolve,
    input  logic [BR_W-1:0]       io_brupdate_mispredict,
    input  logic                  io_flush,
    output logic                  io_resp_valid,
    input  logic                  io_resp_ready,
    output logic [BR_W-1:0]       io_resp_bits_uop_br_mask,
    output logic [VADDR_BITS:0]   io_resp_bits_addr,
    output logic                  io_resp_bits_mxcpt_valid,
    output logic [3:0]            io_resp_bits_mxcpt_cause,
    output logic                  io_resp_bits_sfence_valid,
    output logic                  io_resp_bits_sfence_rs1,
    output logic                  io_resp_bits_sfence_rs2,
    output logic [VADDR_BITS-1:0] io_resp_bits_sfence_addr,
    output logic                  io_busy
);

    localparam int PAY_W = 2 * VADDR_BITS + 9;

    logic [XLEN-1:0]         base_p0;
    logic [XLEN-1:0]         imm_p0;
    logic [XLEN-1:0]         a_p0;
    logic [XLEN-VADDR_BITS:0] hi_p0;
    logic [64:0]             comp_p0;
    logic [VADDR_BITS:0]     addr_p0;
    logic                    is_ld_p0;
    logic                    is_st_p0;
    logic                    is_sfence_p0;
    logic                    misalign_p0;
    logic                    noncanon_p0;
    logic                    mx_p0;
    logic [3:0]              cause_p0;
    logic [PAY_W-1:0]        pay_p0;

    assign base_p0      = io_req_bits_rs1_data[XLEN-1:0];
    assign imm_p0       = {{(XLEN-12){io_req_bits_uop.imm_packed[19]}}, io_req_bits_uop.imm_packed[19:8]};
    assign a_p0         = base_p0 + imm_p0;
    assign hi_p0        = a_p0[XLEN-1:VADDR_BITS-1];
    assign noncanon_p0  = !((&hi_p0) || !(|hi_p0));
    assign comp_p0      = canon_compress(64'(a_p0), XLEN, VADDR_BITS);
    assign addr_p0      = comp_p0[VADDR_BITS:0];
    assign is_ld_p0     = io_req_bits_uop.uopc == UOPC_LD;
    assign is_st_p0     = io_req_bits_uop.uopc == UOPC_STA || io_req_bits_uop.uopc == UOPC_AMO;
    assign is_sfence_p0 = io_req_bits_uop.mem_cmd == M_SFENCE;

    always_comb begin
        misalign_p0 = 1'b0;
        case (io_req_bits_uop.mem_size)
            2'd1:    misalign_p0 = a_p0[0];
            2'd2:    misalign_p0 = |a_p0[1:0];
            2'd3:    misalign_p0 = |a_p0[2:0];
            default: misalign_p0 = 1'b0;
        endcase
    end

    // Misalign wins over access fault; sfence never reports an exception.
    always_comb begin
        mx_p0    = 1'b0;
        cause_p0 = CAUSE_NONE;
        if (!is_sfence_p0) begin
            if (is_ld_p0 && misalign_p0) begin
                mx_p0    = 1'b1;
                cause_p0 = CAUSE_LD_MISALIGN;
            end else if (is_st_p0 && misalign_p0) begin
                mx_p0    = 1'b1;
                cause_p0 = CAUSE_ST_MISALIGN;
            end else if (is_ld_p0 && noncanon_p0) begin
                mx_p0    = 1'b1;
                cause_p0 = CAUSE_LD_FAULT;
            end else if (is_st_p0 && noncanon_p0) begin
                mx_p0    = 1'b1;
                cause_p0 = CAUSE_ST_FAULT;
            end
        end
    end

    assign pay_p0 = {addr_p0, mx_p0, cause_p0, is_sfence_p0,
                     io_req_bits_uop.mem_size[0], io_req_bits_uop.mem_size[1],
                     base_p0[VADDR_BITS-1:0]};

    // ---- stage registers ----
    logic [LATENCY-1:0] stg_vld;
    logic [BR_W-1:0]    stg_msk [LATENCY];
    logic [PAY_W-1:0]   stg_pay [LATENCY];
    logic [LATENCY:0]   rdy;

    // Stage i may load when some stage at or after i is empty, or the consumer drains.
    always_comb begin
        rdy          = '0;
        rdy[LATENCY] = io_resp_ready;
        for (int i = LATENCY - 1; i >= 0; i--) begin
            rdy[i] = !stg_vld[i] || rdy[i+1];
        end
    end

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        logic              in_vld;
        logic [BR_W-1:0]   in_msk;
        logic [PAY_W-1:0]  in_pay;
        if (g == 0) begin : g_head
            assign in_vld = io_req_valid;
            assign in_msk = io_req_bits_uop.br_mask[BR_W-1:0];
            assign in_pay = pay_p0;
        end else begin : g_body
            assign in_vld = stg_vld[g-1];
            assign in_msk = stg_msk[g-1];
            assign in_pay = stg_pay[g-1];
        end
        mem_addr_calc_stage #(
            .DATA_W (PAY_W),
            .BR_W   (BR_W)
        ) u_stage (
            .clock       (clock),
            .reset       (reset),
            .flush       (io_flush),
            .in_valid    (in_vld),
            .in_br_mask  (in_msk),
            .in_data     (in_pay),
            .resolve     (io_brupdate_resolve),
            .mispredict  (io_brupdate_mispredict),
            .out_ready   (rdy[g+1]),
            .out_valid   (stg_vld[g]),
            .out_br_mask (stg_msk[g]),
            .out_data    (stg_pay[g])
        );
    end

    // ---- output stage ----
    logic sf_cmd;

    assign {io_resp_bits_addr, io_resp_bits_mxcpt_valid, io_resp_bits_mxcpt_cause, sf_cmd,
            io_resp_bits_sfence_rs1, io_resp_bits_sfence_rs2, io_resp_bits_sfence_addr} = stg_pay[LATENCY-1];

    assign io_resp_valid             = stg_vld[LATENCY-1] && ((stg_msk[LATENCY-1] & io_brupdate_mispredict) == '0);
    assign io_resp_bits_uop_br_mask  = stg_msk[LATENCY-1];
    assign io_resp_bits_sfence_valid = io_resp_valid && sf_cmd;
    assign io_req_ready              = rdy[0];
    assign io_busy                   = |stg_vld;

    logic unused_bits;
    assign unused_bits = ^{io_req_bits_rs2_data[XLEN-1:0], io_req_bits_rs1_data[XLEN],
                           io_req_bits_uop.imm_packed[7:0], comp_p0[64:VADDR_BITS+1]};

    logic accept;
    assign accept = io_req_valid && io_req_ready && !io_flush;

    a_std_tag: assert property (@(posedge clock) disable iff (reset)
        (accept && io_req_bits_uop.is_std) |-> !io_req_bits_rs2_data[XLEN]);
    a_std_fp: assert property (@(posedge clock) disable iff (reset)
        (accept && io_req_bits_uop.is_std) |-> !io_req_bits_uop.fp_val);
    a_fp_mem: assert property (@(posedge clock) disable iff (reset)
        (accept && io_req_bits_uop.fp_val) |-> (is_ld_p0 || is_st_p0));
    a_ma_excl: assert property (@(posedge clock) disable iff (reset)
        accept |-> !(is_ld_p0 && misalign_p0 && is_st_p0));

endmodule

// File: tb/tb_mem_addr_calc_pipe.sv
// Directed-vector bench for mem_addr_calc_pipe (LATENCY=2, XLEN=64, VADDR_BITS=39).
module tb_mem_addr_calc_pipe;
    import memaddr_pkg::*;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    uop_t        uop;
    logic [64:0] rs1_data;
    logic [64:0] rs2_data;
    logic [15:0] resolve;
    logic [15:0] mispredict;
    logic        flush;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_br_mask;
    logic [39:0] resp_addr;
    logic        mx_valid;
    logic [3:0]  mx_cause;
    logic        sf_valid;
    logic        sf_rs1;
    logic        sf_rs2;
    logic [38:0] sf_addr;
    logic        busy;

    int total;
    int passed;

    mem_addr_calc_pipe #(.XLEN(64), .VADDR_BITS(39), .BR_W(16), .LATENCY(2)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .io_req_valid             (req_valid),
        .io_req_ready             (req_ready),
        .io_req_bits_uop          (uop),
        .io_req_bits_rs1_data     (rs1_data),
        .io_req_bits_rs2_data     (rs2_data),
        .io_brupdate_resolve      (resolve),
        .io_brupdate_mispredict   (mispredict),
        .io_flush                 (flush),
        .io_resp_valid            (resp_valid),
        .io_resp_ready            (resp_ready),
        .io_resp_bits_uop_br_mask (resp_br_mask),
        .io_resp_bits_addr        (resp_addr),
        .io_resp_bits_mxcpt_valid (mx_valid),
        .io_resp_bits_mxcpt_cause (mx_cause),
        .io_resp_bits_sfence_valid(sf_valid),
        .io_resp_bits_sfence_rs1  (sf_rs1),
        .io_resp_bits_sfence_rs2  (sf_rs2),
        .io_resp_bits_sfence_addr (sf_addr),
        .io_busy                  (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [6:0]  uopc;
        logic [11:0] imm;
        logic [1:0]  size;
        logic [4:0]  cmd;
        logic [63:0] rs1;
        logic [39:0] addr;
        logic        mx;
        logic [3:0]  cause;
        logic        sf;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else passed++;
    endtask

    task automatic drive_req(input logic [6:0] uopc, input logic [11:0] imm, input logic [1:0] size,
                             input logic [4:0] cmd, input logic [63:0] rs1, input logic [15:0] mask);
        uop            = '0;
        uop.uopc       = uopc;
        uop.imm_packed = {imm, 8'h00};
        uop.mem_size   = size;
        uop.mem_cmd    = cmd;
        uop.br_mask    = mask;
        rs1_data       = {1'b0, rs1};
        req_valid      = 1'b1;
    endtask

    int sent, recv, seen_a, seen_b;
    logic saw_stall;

    initial begin
        total = 0; passed = 0;
        vecs[0]  = '{"ld_basic",    UOPC_LD,  12'h008, 2'd3, 5'h00, 64'h1000,                40'h1008,        1'b0, 4'd0, 1'b0};
        vecs[1]  = '{"st_misalign", UOPC_STA, 12'h000, 2'd2, 5'h01, 64'h1001,                40'h1001,        1'b1, 4'd6, 1'b0};
        vecs[2]  = '{"ld_fault",    UOPC_LD,  12'h000, 2'd3, 5'h00, 64'h0000_0080_0000_0000, 40'hC0_0000_0000, 1'b1, 4'd5, 1'b0};
        vecs[3]  = '{"ld_half_ma",  UOPC_LD,  12'h000, 2'd1, 5'h00, 64'h2001,                40'h2001,        1'b1, 4'd4, 1'b0};
        vecs[4]  = '{"amo_ma",      UOPC_AMO, 12'h000, 2'd3, 5'h01, 64'h3004,                40'h3004,        1'b1, 4'd6, 1'b0};
        vecs[5]  = '{"ld_neg_canon",UOPC_LD,  12'h000, 2'd3, 5'h00, 64'hFFFF_FFC0_0000_0000, 40'hC0_0000_0000, 1'b0, 4'd0, 1'b0};
        vecs[6]  = '{"st_neg_imm",  UOPC_STA, 12'hFF0, 2'd2, 5'h01, 64'h1000,                40'h0FF0,        1'b0, 4'd0, 1'b0};
        vecs[7]  = '{"ma_over_flt", UOPC_STA, 12'h000, 2'd1, 5'h01, 64'h0000_0040_0000_0001, 40'h1,           1'b1, 4'd6, 1'b0};
        vecs[8]  = '{"non_mem",     7'h05,    12'h000, 2'd3, 5'h00, 64'h1001,                40'h1001,        1'b0, 4'd0, 1'b0};
        vecs[9]  = '{"sfence",      UOPC_LD,  12'h000, 2'd2, 5'h14, 64'h123,                 40'h123,         1'b0, 4'd0, 1'b1};
        vecs[10] = '{"st_fault",    UOPC_STA, 12'h000, 2'd3, 5'h01, 64'hFFFF_0000_0000_0000, 40'hC0_0000_0000, 1'b1, 4'd7, 1'b0};

        reset = 1'b1; req_valid = 1'b0; uop = '0; rs1_data = '0; rs2_data = '0;
        resolve = '0; mispredict = '0; flush = 1'b0; resp_ready = 1'b1;
        tick(); tick();
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        reset = 1'b0;
        tick();

        // Single requests, one at a time, consumer always ready.
        for (int i = 0; i < 11; i++) begin
            drive_req(vecs[i].uopc, vecs[i].imm, vecs[i].size, vecs[i].cmd, vecs[i].rs1, 16'h0);
            tick();
            req_valid = 1'b0;
            #1;
            chk({vecs[i].name, "_early"}, 64'(resp_valid), 64'd0);
            tick();
            chk({vecs[i].name, "_valid"}, 64'(resp_valid), 64'd1);
            chk({vecs[i].name, "_addr"}, 64'(resp_addr), 64'(vecs[i].addr));
            chk({vecs[i].name, "_mx"}, 64'(mx_valid), 64'(vecs[i].mx));
            if (vecs[i].mx) chk({vecs[i].name, "_cause"}, 64'(mx_cause), 64'(vecs[i].cause));
            chk({vecs[i].name, "_sfv"}, 64'(sf_valid), 64'(vecs[i].sf));
            if (vecs[i].sf) begin
                chk("sfence_rs1", 64'(sf_rs1), 64'd0);
                chk("sfence_rs2", 64'(sf_rs2), 64'd1);
                chk("sfence_addr", 64'(sf_addr), 64'h123);
            end
            tick();
            chk({vecs[i].name, "_drained"}, 64'(busy), 64'd0);
        end

        // Back-to-back requests with the consumer stalled for three cycles.
        sent = 0; recv = 0; saw_stall = 1'b0;
        for (int c = 0; c < 30; c++) begin
            resp_ready = (c >= 3);
            if (sent < 4) drive_req(UOPC_LD, 12'h000, 2'd3, 5'h00, 64'((sent + 1) * 'h100), 16'h0);
            else req_valid = 1'b0;
            #1;
            if (req_valid && !req_ready) saw_stall = 1'b1;
            if (resp_valid && resp_ready) begin
                chk("seq_order", 64'(resp_addr), 64'((recv + 1) * 'h100));
                recv++;
            end
            if (req_valid && req_ready) sent++;
            @(posedge clock); #1;
        end
        chk("seq_stall_seen", 64'(saw_stall), 64'd1);
        chk("seq_sent", 64'(sent), 64'd4);
        chk("seq_recv", 64'(recv), 64'd4);
        chk("seq_idle", 64'(busy), 64'd0);

        // Mispredict kills a stalled uop sitting in the first register.
        resp_ready = 1'b0;
        drive_req(UOPC_LD, 12'h000, 2'd3, 5'h00, 64'h600, 16'h0000);
        tick();
        drive_req(UOPC_LD, 12'h000, 2'd3, 5'h00, 64'h700, 16'h0004);
        tick();
        req_valid = 1'b0;
        mispredict = 16'h0004;
        tick();
        mispredict = 16'h0000;
        resp_ready = 1'b1;
        seen_a = 0; seen_b = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (resp_valid && resp_ready) begin
                if (resp_addr == 40'h700) seen_b++;
                else if (resp_addr == 40'h600) seen_a++;
            end
            @(posedge clock); #1;
        end
        chk("kill_survivor", 64'(seen_a), 64'd1);
        chk("kill_victim", 64'(seen_b), 64'd0);

        // Mispredict on the output stage gates resp_valid in the same cycle.
        resp_ready = 1'b0;
        drive_req(UOPC_LD, 12'h000, 2'd3, 5'h00, 64'h800, 16'h0004);
        tick();
        req_valid = 1'b0;
        tick();
        chk("kill_out_pre", 64'(resp_valid), 64'd1);
        mispredict = 16'h0004;
        #1;
        chk("kill_out_comb", 64'(resp_valid), 64'd0);
        tick();
        mispredict = 16'h0000;
        #1;
        chk("kill_out_gone", 64'(busy), 64'd0);

        // Incoming request killed on the cycle it is presented.
        resp_ready = 1'b1;
        drive_req(UOPC_LD, 12'h000, 2'd3, 5'h00, 64'h880, 16'h0004);
        mispredict = 16'h0004;
        tick();
        req_valid = 1'b0;
        mispredict = 16'h0000;
        #1;
        chk("kill_incoming", 64'(busy), 64'd0);

        // Resolve clears the matching br_mask bit of a stalled uop.
        resp_ready = 1'b0;
        drive_req(UOPC_LD, 12'h000, 2'd3, 5'h00, 64'h900, 16'h0004);
        tick();
        req_valid = 1'b0;
        tick();
        chk("resolve_pre_mask", 64'(resp_br_mask), 64'h0004);
        resolve = 16'h0004;
        tick();
        resolve = 16'h0000;
        #1;
        chk("resolve_mask", 64'(resp_br_mask), 64'h0000);
        chk("resolve_valid", 64'(resp_valid), 64'd1);
        resp_ready = 1'b1;
        tick();
        chk("resolve_drained", 64'(busy), 64'd0);

        // Flush with full pipe and a request presented: everything dropped.
        resp_ready = 1'b0;
        drive_req(UOPC_LD, 12'h000, 2'd3, 5'h00, 64'hA00, 16'h0);
        tick();
        drive_req(UOPC_LD, 12'h000, 2'd3, 5'h00, 64'hB00, 16'h0);
        tick();
        drive_req(UOPC_LD, 12'h000, 2'd3, 5'h00, 64'hC00, 16'h0);
        flush = 1'b1;
        #1;
        chk("flush_full", 64'(busy), 64'd1);
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_resp", 64'(resp_valid), 64'd0);
        resp_ready = 1'b1;
        tick();
        chk("flush_dropped", 64'(resp_valid), 64'd0);

        // Reset mid-stream.
        drive_req(UOPC_LD, 12'h000, 2'd3, 5'h00, 64'hD00, 16'h0);
        tick();
        drive_req(UOPC_LD, 12'h000, 2'd3, 5'h00, 64'hE00, 16'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("midrst_resp", 64'(resp_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
